// File: rtl/rhythm_pkg.sv
// Lane geometry and widths shared by the note scroller and the strum hit checker,
// so both sides always agree on where the hit window is.
package rhythm_pkg;

  localparam int unsigned NUM_BITS   = 10;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned PTR_BITS   = $clog2(DEPTH);
  localparam int unsigned COUNT_BITS = $clog2(DEPTH) + 1;

  localparam logic [NUM_BITS-1:0] CENTER    = 10'h1F4;
  localparam logic [NUM_BITS-1:0] TOLERANCE = 10'h018;
  localparam logic [NUM_BITS-1:0] SPAWN_Y   = 10'h000;
  localparam logic [NUM_BITS-1:0] SPEED     = 10'h004;

  typedef logic [NUM_BITS:0] wide_y_t;

  // True when one more advance would carry y beyond the far edge of the hit window.
  function automatic logic past_window(input logic [NUM_BITS-1:0] y);
    return (wide_y_t'(y) + wide_y_t'(SPEED)) > (wide_y_t'(CENTER) + wide_y_t'(TOLERANCE));
  endfunction

endpackage

// File: rtl/note_ring.sv
// Circular buffer of note Y positions with push at tail, pop at head and a
// per-frame advance of every slot; also exposes its next-state head for output registering.
module note_ring
  import rhythm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  advance,
  input  logic [NUM_BITS-1:0]   push_data,
  output logic [NUM_BITS-1:0]   head_y,
  output logic [NUM_BITS-1:0]   head_next_c,
  output logic [COUNT_BITS-1:0] count,
  output logic [COUNT_BITS-1:0] count_next_c,
  output logic                  full,
  output logic                  empty
);

  logic [NUM_BITS-1:0]   mem   [DEPTH];
  logic [NUM_BITS-1:0]   mem_n [DEPTH];
  logic [PTR_BITS-1:0]   head, head_n;
  logic [PTR_BITS-1:0]   tail, tail_n;

  // Advance applies to every slot; a push lands after the advance so new notes start at push_data.
  always_comb begin
    mem_n = mem;
    if (advance) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_n[i] = mem[i] + SPEED;
      end
    end
    if (push) begin
      mem_n[tail] = push_data;
    end
    head_n       = pop  ? head + PTR_BITS'(1) : head;
    tail_n       = push ? tail + PTR_BITS'(1) : tail;
    count_next_c = count + COUNT_BITS'(push) - COUNT_BITS'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_next_c;
    end
  end

  // Slot contents are don't-care after reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    mem <= mem_n;
  end

  assign head_y      = mem[head];
  assign head_next_c = mem_n[head_n];
  assign full        = (count == COUNT_BITS'(DEPTH));
  assign empty       = (count == '0);

endmodule

// File: rtl/note_lane_scroller.sv
// Per-lane note source: spawns chart notes on their frame, scrolls them once per
// frame, retires the head on a hit or when it scrolls past the window.
module note_lane_scroller
  import rhythm_pkg::*;
(
  input  logic                  frameClk,
  input  logic                  resetN,
  input  logic                  run,
  input  logic                  chartValid,
  input  logic [FRAME_BITS-1:0] chartFrame,
  output logic                  chartPop,
  input  logic                  addHit,
  output logic [NUM_BITS-1:0]   Y,
  output logic                  timerActive,
  output logic                  lateMiss,
  output logic                  spawnDrop,
  output logic [COUNT_BITS-1:0] count,
  output logic [FRAME_BITS-1:0] frameCount
);

  logic                  push, pop, hit_retire, late_retire, spawn_req, drop;
  logic                  full, empty;
  logic [NUM_BITS-1:0]   head_y, head_next;
  logic [COUNT_BITS-1:0] count_next;

  note_ring u_ring (
    .clk          (frameClk),
    .rst_n        (resetN),
    .push         (push),
    .pop          (pop),
    .advance      (run),
    .push_data    (SPAWN_Y),
    .head_y       (head_y),
    .head_next_c  (head_next),
    .count        (count),
    .count_next_c (count_next),
    .full         (full),
    .empty        (empty)
  );

  // A hit wins over a late miss when both apply in the same frame.
  always_comb begin
    hit_retire  = run && !empty && addHit;
    late_retire = run && !empty && !addHit && past_window(head_y);
    pop         = hit_retire || late_retire;
    spawn_req   = run && chartValid && (chartFrame == frameCount);
    push        = spawn_req && (!full || pop);
    drop        = spawn_req && full && !pop;
    chartPop    = spawn_req;
  end

  always_ff @(posedge frameClk) begin
    if (!resetN) begin
      Y           <= '0;
      timerActive <= 1'b0;
      lateMiss    <= 1'b0;
      spawnDrop   <= 1'b0;
      frameCount  <= '0;
    end else begin
      Y           <= (count_next == '0) ? '0 : head_next;
      timerActive <= (count_next != '0);
      lateMiss    <= late_retire;
      spawnDrop   <= drop;
      if (run) begin
        frameCount <= frameCount + FRAME_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench for note_lane_scroller: spawn, scroll, hit, late miss, full lane,
// freeze and mid-song reset, with hand-computed expectations.
module tb_note_lane_scroller;

  logic        frameClk;
  logic        resetN;
  logic        run;
  logic        chartValid;
  logic [15:0] chartFrame;
  logic        chartPop;
  logic        addHit;
  logic [9:0]  Y;
  logic        timerActive;
  logic        lateMiss;
  logic        spawnDrop;
  logic [2:0]  count;
  logic [15:0] frameCount;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [15:0] exp_fc;

  note_lane_scroller dut (
    .frameClk    (frameClk),
    .resetN      (resetN),
    .run         (run),
    .chartValid  (chartValid),
    .chartFrame  (chartFrame),
    .chartPop    (chartPop),
    .addHit      (addHit),
    .Y           (Y),
    .timerActive (timerActive),
    .lateMiss    (lateMiss),
    .spawnDrop   (spawnDrop),
    .count       (count),
    .frameCount  (frameCount)
  );

  initial begin
    frameClk = 1'b0;
    forever #5 frameClk = ~frameClk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One frame edge; outputs are settled 2 time units after it.
  task automatic step();
    @(posedge frameClk);
    #2;
    if (!resetN)  exp_fc = 16'd0;
    else if (run) exp_fc = exp_fc + 16'd1;
  endtask

  task automatic check_state(input string tag, input logic [9:0] ey, input logic [2:0] ec,
                             input logic el, input logic ed);
    check({tag, ".Y"}, 32'(Y), 32'(ey));
    check({tag, ".count"}, 32'(count), 32'(ec));
    check({tag, ".timerActive"}, 32'(timerActive), 32'(ec != 3'd0));
    check({tag, ".lateMiss"}, 32'(lateMiss), 32'(el));
    check({tag, ".spawnDrop"}, 32'(spawnDrop), 32'(ed));
    check({tag, ".frameCount"}, 32'(frameCount), 32'(exp_fc));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    exp_fc     = 16'd0;
    resetN     = 1'b0;
    run        = 1'b0;
    chartValid = 1'b0;
    chartFrame = 16'd0;
    addHit     = 1'b0;
    step();
    step();
    check_state("reset", 10'd0, 3'd0, 1'b0, 1'b0);

    // Single note at chartFrame 5, scrolled out as a late miss.
    resetN     = 1'b1;
    run        = 1'b1;
    chartValid = 1'b1;
    chartFrame = 16'd5;
    for (int f = 0; f < 5; f++) begin
      #1 check("pop_early", 32'(chartPop), 32'd0);
      step();
    end
    #1 check("pop_at_5", 32'(chartPop), 32'd1);
    step();
    chartValid = 1'b0;
    check_state("spawn", 10'd0, 3'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 131; k++) begin
      step();
      check("scroll_y", 32'(Y), 32'(4 * k));
    end
    check("scroll_max", 32'(Y), 32'h20C);
    check("scroll_active", 32'(timerActive), 32'd1);
    step();
    check_state("late", 10'd0, 3'd0, 1'b1, 1'b0);
    step();
    check("late_pulse_end", 32'(lateMiss), 32'd0);

    // Same note struck while on the hit line.
    chartValid = 1'b1;
    chartFrame = exp_fc;
    #1 check("pop_hit_note", 32'(chartPop), 32'd1);
    step();
    chartValid = 1'b0;
    for (int k = 0; k < 125; k++) step();
    check("at_center", 32'(Y), 32'h1F4);
    addHit = 1'b1;
    step();
    addHit = 1'b0;
    check_state("hit", 10'd0, 3'd0, 1'b0, 1'b0);
    step();
    check("hit_no_late", 32'(lateMiss), 32'd0);

    // Fill the lane, then overflow it.
    chartValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chartFrame = exp_fc;
      step();
    end
    check_state("full", 10'd12, 3'd4, 1'b0, 1'b0);
    chartFrame = exp_fc;
    #1 check("pop_when_full", 32'(chartPop), 32'd1);
    step();
    chartValid = 1'b0;
    check_state("drop", 10'd16, 3'd4, 1'b0, 1'b1);
    step();
    check_state("drop_end", 10'd20, 3'd4, 1'b0, 1'b0);

    // Full lane, hit plus spawn in the same frame: room is made, nothing dropped.
    chartValid = 1'b1;
    chartFrame = exp_fc;
    addHit     = 1'b1;
    step();
    chartValid = 1'b0;
    addHit     = 1'b0;
    check_state("hit_spawn", 10'd20, 3'd4, 1'b0, 1'b0);

    // Freeze for 10 frames while the inputs wiggle.
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      addHit     = k[0];
      chartValid = ~k[0];
      chartFrame = exp_fc;
      #1 check("frozen_pop", 32'(chartPop), 32'd0);
      step();
      check_state("frozen", 10'd20, 3'd4, 1'b0, 1'b0);
    end
    addHit     = 1'b0;
    chartValid = 1'b0;
    run        = 1'b1;
    step();
    check_state("resume1", 10'd24, 3'd4, 1'b0, 1'b0);
    step();
    check_state("resume2", 10'd28, 3'd4, 1'b0, 1'b0);

    // Head reaches the window edge; its late retire frees a slot for a spawn.
    for (int k = 0; k < 124; k++) step();
    check_state("edge", 10'h20C, 3'd4, 1'b0, 1'b0);
    chartValid = 1'b1;
    chartFrame = exp_fc;
    step();
    chartValid = 1'b0;
    check_state("late_spawn", 10'h20C, 3'd4, 1'b1, 1'b0);
    step();
    check_state("late_second", 10'h20C, 3'd3, 1'b1, 1'b0);

    // Mid-song reset with three notes active.
    resetN = 1'b0;
    step();
    check_state("mid_reset", 10'd0, 3'd0, 1'b0, 1'b0);
    resetN     = 1'b1;
    chartValid = 1'b1;
    chartFrame = 16'd0;
    #1 check("pop_after_reset", 32'(chartPop), 32'd1);
    step();
    chartValid = 1'b0;
    check_state("spawn_after_reset", 10'd0, 3'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
